button_event: RTL

- Upstream front-end for each push switch. It feeds the counter and LED logic that drives the two 7-segment digits.
- Synchronises the raw switch, debounces it, and emits single-cycle press and release strobes.
- Optionally emits auto-repeat strobes while the switch is held, so a held button keeps stepping a digit.
- One instance per switch. All outputs are registered.

---
 rtl/button_pkg.sv | 22 ++
 rtl/switch_filter.sv | 56 +++++
 rtl/button_event.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared types and constants for the push-switch front-end.
// Default timing assumes a 25 MHz clock_sys domain.
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 250_000;     // 10 ms
  localparam int DEF_HOLD_CYCLES     = 12_500_000;  // 0.5 s
  localparam int DEF_REPEAT_CYCLES   = 2_500_000;   // 0.1 s

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/switch_filter.sv
// Two-flop synchroniser plus debounce counter for one raw switch input.
// level_next exposes the value level will take on the next edge so callers can register edge strobes.
module switch_filter
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic switch_in,
  output logic level,
  output logic level_next
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any cycle where sync2 agrees with level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= switch_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level      = level_q;
  assign level_next = level_d;

endmodule

// File: rtl/button_event.sv
// Push-switch front-end: debounced level, press/release strobes and optional auto-repeat.
// Auto-repeat FSM is built only when BUTTON_AUTO_REPEAT_EN is defined.
module button_event
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic switch_in,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic event_pulse
);

  logic level_w;
  logic level_nxt_w;
  logic press_d;
  logic release_d;
  logic repeat_d;
  logic event_d;
  logic press_q;
  logic release_q;
  logic event_q;

  switch_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_filter (
    .clock      (clock),
    .reset_n    (reset_n),
    .switch_in  (switch_in),
    .level      (level_w),
    .level_next (level_nxt_w)
  );

  // Strobes are decided from the upcoming level so they land in its first cycle.
  assign press_d   = level_nxt_w & ~level_w;
  assign release_d = ~level_nxt_w & level_w;
  assign event_d   = press_d | repeat_d;

`ifdef BUTTON_AUTO_REPEAT_EN
  // state     | meaning
  // ST_IDLE   | released, waiting for a press strobe
  // ST_HOLD   | held, timing the initial hold delay
  // ST_REPEAT | held, emitting periodic repeat strobes
  localparam int            RW        = cnt_width((HOLD_CYCLES > REPEAT_CYCLES) ?
                                                  HOLD_CYCLES : REPEAT_CYCLES);
  localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] RCNT_ONE  = RW'(1);

  rpt_state_e    state_q;
  rpt_state_e    state_d;
  logic [RW-1:0] rcnt_q;
  logic [RW-1:0] rcnt_d;
  logic          repeat_q;

  // The counter runs one cycle ahead of the registered strobe, so repeat_d
  // fires on the edge that makes repeat_pulse visible HOLD/REPEAT cycles later.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    repeat_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rcnt_d = '0;
        if (press_d) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (release_d) begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == HOLD_LAST) begin
          repeat_d = 1'b1;
          rcnt_d   = '0;
          state_d  = ST_REPEAT;
        end else begin
          rcnt_d = rcnt_q + RCNT_ONE;
        end
      end
      ST_REPEAT: begin
        if (release_d) begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == RPT_LAST) begin
          repeat_d = 1'b1;
          rcnt_d   = '0;
        end else begin
          rcnt_d = rcnt_q + RCNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rcnt_q   <= '0;
      repeat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      repeat_q <= repeat_d;
    end
  end

  assign repeat_pulse = repeat_q;
`else
  logic unused_cfg;

  assign repeat_d     = 1'b0;
  assign repeat_pulse = 1'b0;
  assign unused_cfg   = |{HOLD_CYCLES, REPEAT_CYCLES};
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      event_q   <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      event_q   <= event_d;
    end
  end

  assign level         = level_w;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign event_pulse   = event_q;

endmodule
